// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 3-sample majority voting and a held output register.
// Latency: flags and rx_valid rise 1 clk after the tick that takes the centre sample of the last stop bit.
// Backpressure: none upstream; a completed frame is dropped and overrun set while rx_valid is high without rx_ack.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 uart_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] SMP_A = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SMP_B = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SMP_C = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   smp_a_q, smp_a_d, smp_b_q, smp_b_d;
    logic                   par_q, par_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   perr_q, perr_d;
    logic                   ovr_q, ovr_d;
    logic                   brk_q, brk_d;

    logic [CW-1:0] cnt_nx;
    logic          maj, complete;
    logic          new_ferr, new_perr, brk_frame, par_xor;

    // The bit decision is made on the third sample, so the vote uses the live synchronised input.
    assign cnt_nx   = cnt_q + 1'b1;
    assign maj      = (smp_a_q & smp_b_q) | (smp_a_q & sync2_q) | (smp_b_q & sync2_q);
    assign par_xor  = (^shift_q) ^ par_q;
    assign new_perr = (PARITY == 1) ? par_xor : ((PARITY == 2) ? ~par_xor : 1'b0);
    assign new_ferr = ferr_acc_q | ~maj;
    assign brk_frame = (shift_q == '0) && ((PARITY == 0) || !par_q) && !maj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            smp_a_q    <= 1'b1;
            smp_b_q    <= 1'b1;
            par_q      <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            sync1_q    <= rxd;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            smp_a_q    <= smp_a_d;
            smp_b_q    <= smp_b_d;
            par_q      <= par_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        smp_a_d    = smp_a_q;
        smp_b_d    = smp_b_q;
        par_d      = par_q;
        ferr_acc_d = ferr_acc_q;
        complete   = 1'b0;
        if (uart_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!sync2_q) begin
                        cnt_d      = '0;
                        bit_cnt_d  = '0;
                        ferr_acc_d = 1'b0;
                        state_d    = S_START;
                    end
                end
                S_BREAK_WAIT: begin
                    if (sync2_q) state_d = S_IDLE;
                end
                default: begin
                    cnt_d = cnt_nx;
                    if (cnt_nx == SMP_A) smp_a_d = sync2_q;
                    if (cnt_nx == SMP_B) smp_b_d = sync2_q;
                    case (state_q)
                        S_START: begin
                            if (cnt_nx == SMP_C && maj) state_d = S_IDLE;
                            else if (cnt_nx == '0)      state_d = S_DATA;
                        end
                        S_DATA: begin
                            if (cnt_nx == SMP_C) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                            if (cnt_nx == '0) begin
                                if (bit_cnt_q == LAST_DATA) begin
                                    bit_cnt_d = '0;
                                    state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + 4'd1;
                                end
                            end
                        end
                        S_PARITY: begin
                            if (cnt_nx == SMP_C) par_d = maj;
                            if (cnt_nx == '0)    state_d = S_STOP;
                        end
                        S_STOP: begin
                            // Complete at the centre of the last stop bit so the next start edge is not missed.
                            if (cnt_nx == SMP_C) begin
                                if (!maj) ferr_acc_d = 1'b1;
                                if (bit_cnt_q == LAST_STOP) begin
                                    complete = 1'b1;
                                    state_d  = brk_frame ? S_BREAK_WAIT : S_IDLE;
                                end
                            end else if (cnt_nx == '0) begin
                                bit_cnt_d = bit_cnt_q + 4'd1;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            endcase
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        brk_d   = brk_q;
        if (complete) begin
            if (!valid_q || rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                ferr_d  = new_ferr;
                perr_d  = new_perr;
                brk_d   = brk_frame;
                ovr_d   = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_ack && valid_q) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
            brk_d   = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign break_det  = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7O2 instance, tick every 4 clk, OVERSAMPLE = 16.
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] tdiv = 2'd0;
    logic       uart_tick;
    always @(posedge clk) tdiv <= tdiv + 2'd1;
    assign uart_tick = (tdiv == 2'd0);

    logic       rxd_a, ack_a, rxd_b, ack_b;
    logic [7:0] a_data;
    logic       a_valid, a_ferr, a_perr, a_ovr, a_brk;
    logic [6:0] b_data;
    logic       b_valid, b_ferr, b_perr, b_ovr, b_brk;

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .uart_tick(uart_tick),
        .rx_data(a_data), .rx_valid(a_valid), .rx_ack(ack_a),
        .frame_err(a_ferr), .parity_err(a_perr), .overrun(a_ovr), .break_det(a_brk)
    );

    uart_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .uart_tick(uart_tick),
        .rx_data(b_data), .rx_valid(b_valid), .rx_ack(ack_b),
        .frame_err(b_ferr), .parity_err(b_perr), .overrun(b_ovr), .break_det(b_brk)
    );

    int   checks = 0;
    int   fails  = 0;
    logic drv_done;

    typedef struct {
        int         sel;
        logic [8:0] dat;
        logic       par;
        logic       stopv;
        int         gbit;
        logic [8:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
        logic       exp_brk;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {8'd0, act}, {8'd0, exp});
    endtask

    function automatic logic [8:0] get_data(input int sel);
        return (sel == 0) ? {1'b0, a_data} : {2'b00, b_data};
    endfunction

    // {valid, frame_err, parity_err, overrun, break_det}
    function automatic logic [4:0] get_flags(input int sel);
        return (sel == 0) ? {a_valid, a_ferr, a_perr, a_ovr, a_brk}
                          : {b_valid, b_ferr, b_perr, b_ovr, b_brk};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        do begin
            @(posedge clk);
            #1;
        end while (uart_tick !== 1'b1);
    endtask

    task automatic set_rxd(input int sel, input logic v);
        if (sel == 0) rxd_a = v;
        else          rxd_b = v;
    endtask

    task automatic pulse_ack(input int sel);
        if (sel == 0) ack_a = 1'b1; else ack_b = 1'b1;
        wait_clk(1);
        ack_a = 1'b0;
        ack_b = 1'b0;
    endtask

    // One bit is 16 ticks = 64 clk; a glitch inverts the line for one tick around the bit centre.
    task automatic drive_bit(input int sel, input logic v, input bit glitch);
        set_rxd(sel, v);
        if (!glitch) begin
            wait_clk(64);
        end else begin
            wait_clk(32);
            set_rxd(sel, ~v);
            wait_clk(4);
            set_rxd(sel, v);
            wait_clk(28);
        end
    endtask

    task automatic drive_frame(input int sel, input logic [8:0] dat, input logic par,
                               input logic stopv, input int gbit);
        int nd;
        nd = (sel == 0) ? 8 : 7;
        drive_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < nd; i++) drive_bit(sel, dat[i], (i == gbit));
        if (sel == 1) drive_bit(sel, par, 1'b0);
        for (int i = 0; i < ((sel == 0) ? 1 : 2); i++) drive_bit(sel, stopv, 1'b0);
        set_rxd(sel, 1'b1);
    endtask

    task automatic wait_valid(input int sel, input int maxc, input string name);
        int         n;
        logic [4:0] f;
        n = 0;
        f = get_flags(sel);
        while (f[4] !== 1'b1 && n < maxc) begin
            wait_clk(1);
            n++;
            f = get_flags(sel);
        end
        checks++;
        if (f[4] !== 1'b1) begin
            fails++;
            $display("FAIL %s: rx_valid still 0 after %0d clk, expected 1", name, maxc);
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] f;
        logic [7:0] v8;
        int         extra;

        //          sel  dat     par   stop  gbit data    ferr  perr  brk
        vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, -1, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1, 9'h041, 1'b1, 1'b1, -1, 9'h041, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1, 9'h041, 1'b0, 1'b1, -1, 9'h041, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{0, 9'h055, 1'b0, 1'b1,  2, 9'h055, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{0, 9'h000, 1'b0, 1'b1,  3, 9'h000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{0, 9'h0FF, 1'b0, 1'b1,  7, 9'h0FF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1, 9'h000, 1'b0, 1'b1, -1, 9'h000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1, 9'h041, 1'b1, 1'b0, -1, 9'h041, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1, 9'h000, 1'b0, 1'b0, -1, 9'h000, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; rxd_a = 1'b1; rxd_b = 1'b1; ack_a = 1'b0; ack_b = 1'b0; drv_done = 1'b0;
        wait_clk(3);
        chk("reset_data", get_data(0), 9'h000);
        chk("reset_flags_a", {4'd0, get_flags(0)}, 9'h000);
        chk("reset_flags_b", {4'd0, get_flags(1)}, 9'h000);
        rst_n = 1'b1;
        wait_clk(8);

        // False start: low for 3 ticks only.
        align();
        rxd_a = 1'b0;
        wait_clk(12);
        rxd_a = 1'b1;
        wait_clk(64 * 12);
        chk1("false_start_valid", a_valid, 1'b0);

        for (int r = 0; r < 9; r++) begin
            align();
            drive_frame(vecs[r].sel, vecs[r].dat, vecs[r].par, vecs[r].stopv, vecs[r].gbit);
            wait_clk(128);
            wait_valid(vecs[r].sel, 200, $sformatf("row%0d_valid", r));
            f = get_flags(vecs[r].sel);
            chk($sformatf("row%0d_data", r), get_data(vecs[r].sel), vecs[r].exp_data);
            chk1($sformatf("row%0d_frame_err", r), f[3], vecs[r].exp_ferr);
            chk1($sformatf("row%0d_parity_err", r), f[2], vecs[r].exp_perr);
            chk1($sformatf("row%0d_overrun", r), f[1], 1'b0);
            chk1($sformatf("row%0d_break", r), f[0], vecs[r].exp_brk);
            pulse_ack(vecs[r].sel);
            f = get_flags(vecs[r].sel);
            chk($sformatf("row%0d_after_ack", r), {4'd0, f}, 9'h000);
        end

        // 0x3C with stop bit 0, then the line stays low for 20 bit times.
        align();
        fork
            begin
                v8 = 8'h3C;
                drive_bit(0, 1'b0, 1'b0);
                for (int i = 0; i < 8; i++) drive_bit(0, v8[i], 1'b0);
                rxd_a = 1'b0;
                wait_clk(64 * 20);
                rxd_a = 1'b1;
                drv_done = 1'b1;
            end
            begin
                wait_valid(0, 64 * 12, "ferr_valid");
                chk("ferr_data", get_data(0), 9'h03C);
                chk1("ferr_frame_err", a_ferr, 1'b1);
                chk1("ferr_break", a_brk, 1'b0);
                pulse_ack(0);
                wait_valid(0, 64 * 12, "brk_valid");
                chk("brk_data", get_data(0), 9'h000);
                chk1("brk_break", a_brk, 1'b1);
                chk1("brk_frame_err", a_ferr, 1'b1);
                pulse_ack(0);
                extra = 0;
                while (!drv_done) begin
                    wait_clk(1);
                    if (a_valid) extra++;
                end
                chk("brk_no_repeat", 9'(extra), 9'd0);
            end
        join
        wait_clk(128);
        chk1("brk_release_valid", a_valid, 1'b0);

        // Overrun: two frames without ack keep the first and flag the loss.
        align();
        drive_frame(0, 9'h011, 1'b0, 1'b1, -1);
        wait_clk(128);
        align();
        drive_frame(0, 9'h022, 1'b0, 1'b1, -1);
        wait_clk(128);
        chk("ovr_data", get_data(0), 9'h011);
        chk1("ovr_valid", a_valid, 1'b1);
        chk1("ovr_overrun", a_ovr, 1'b1);
        // Third frame completes on edge 617 after the start edge; ack is held only for that cycle.
        align();
        fork
            drive_frame(0, 9'h033, 1'b0, 1'b1, -1);
            begin
                wait_clk(616);
                chk("ovr_pre_complete_data", get_data(0), 9'h011);
                ack_a = 1'b1;
                wait_clk(1);
                ack_a = 1'b0;
                chk("ovr_ack_data", get_data(0), 9'h033);
                chk1("ovr_ack_valid", a_valid, 1'b1);
                chk1("ovr_ack_overrun", a_ovr, 1'b0);
            end
        join
        wait_clk(128);
        pulse_ack(0);
        chk1("ovr_final_valid", a_valid, 1'b0);

        // Reset mid-frame with a held character present.
        align();
        drive_frame(0, 9'h081, 1'b0, 1'b1, -1);
        wait_clk(128);
        chk("pre_reset_data", get_data(0), 9'h081);
        align();
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 1'b0);
        wait_clk(32);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data", get_data(0), 9'h000);
        chk("rst_mid_flags", {4'd0, get_flags(0)}, 9'h000);
        wait_clk(10);
        rst_n = 1'b1;
        wait_clk(128);
        align();
        drive_frame(0, 9'h05A, 1'b0, 1'b1, -1);
        wait_clk(128);
        wait_valid(0, 200, "post_rst_valid");
        chk("post_rst_data", get_data(0), 9'h05A);
        chk1("post_rst_frame_err", a_ferr, 1'b0);
        pulse_ack(0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
